// File: rtl/inst_buffer_pkg.sv
// Shared definitions for the fetch-to-decode instruction buffer:
// bus widths, the zero word and the packed layout of one queue entry.
package inst_buffer_pkg;

    localparam int REG_BUS_W   = 32;
    localparam int INST_ADDR_W = 32;
    localparam int EXCP_NUM_W  = 9;

    localparam logic [REG_BUS_W-1:0] ZERO_WORD = '0;

    // One queued fetch result; field order gives the 74-bit {excp_num, excp, inst, pc} word.
    typedef struct packed {
        logic [EXCP_NUM_W-1:0]  excp_num;
        logic                   excp;
        logic [REG_BUS_W-1:0]   inst;
        logic [INST_ADDR_W-1:0] pc;
    } ib_entry_t;

    function automatic ib_entry_t pack_entry(
        input logic [INST_ADDR_W-1:0] pc,
        input logic [REG_BUS_W-1:0]   inst,
        input logic                   excp,
        input logic [EXCP_NUM_W-1:0]  excp_num
    );
        ib_entry_t e;
        e.pc       = pc;
        e.inst     = inst;
        e.excp     = excp;
        e.excp_num = excp_num;
        return e;
    endfunction

endpackage

// File: rtl/inst_buffer_mem.sv
// Entry storage for the instruction buffer: DEPTH registered entries,
// one synchronous write port and one asynchronous read port.
module inst_buffer_mem
    import inst_buffer_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [PTR_W-1:0] wr_addr,
    input  ib_entry_t        wr_data,
    input  logic [PTR_W-1:0] rd_addr,
    output ib_entry_t        rd_data
);

    ib_entry_t mem [DEPTH];

    // Payloads are never reset; validity is tracked entirely by the top-level count.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/inst_buffer.sv
// Decoupling queue between instruction fetch and decode. Holds up to DEPTH
// fetched instructions and presents the oldest one; any flush empties it.
module inst_buffer
    import inst_buffer_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   excp_flush,
    input  logic                   ertn_flush,
    input  logic                   fetch_valid_i,
    input  logic [INST_ADDR_W-1:0] fetch_pc_i,
    input  logic [REG_BUS_W-1:0]   fetch_inst_i,
    input  logic                   fetch_excp_i,
    input  logic [EXCP_NUM_W-1:0]  fetch_excp_num_i,
    output logic                   fetch_ready_o,
    input  logic                   dec_ready_i,
    output logic                   dec_valid_o,
    output logic [INST_ADDR_W-1:0] dec_pc_o,
    output logic [REG_BUS_W-1:0]   dec_inst_o,
    output logic                   dec_excp_o,
    output logic [EXCP_NUM_W-1:0]  dec_excp_num_o,
    output logic [PTR_W:0]         count_o
);

    localparam logic [PTR_W:0]   FULL_COUNT = DEPTH[PTR_W:0];
    localparam logic [PTR_W:0]   CNT_ONE    = 1;
    localparam logic [PTR_W-1:0] PTR_ONE    = 1;

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic [PTR_W-1:0] wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_next;
    logic [PTR_W:0]   count_next;

    logic      flush_any;
    logic      push;
    logic      pop;
    ib_entry_t head;

    assign flush_any = flush | excp_flush | ertn_flush;

    // Ready comes only from the registered count, so a pop never frees a slot in the same cycle.
    assign fetch_ready_o = (count < FULL_COUNT);
    assign dec_valid_o   = (count != '0);
    assign push          = fetch_valid_i & fetch_ready_o;
    assign pop           = dec_valid_o & dec_ready_i;

    always_comb begin
        wr_ptr_next = wr_ptr;
        rd_ptr_next = rd_ptr;
        count_next  = count;
        if (push) begin
            wr_ptr_next = wr_ptr + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_next = rd_ptr + PTR_ONE;
        end
        case ({push, pop})
            2'b10:   count_next = count + CNT_ONE;
            2'b01:   count_next = count - CNT_ONE;
            default: count_next = count;
        endcase
    end

    // Reset and every flush flavour discard the contents the same way; pushes and pops are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_any) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr_next;
            rd_ptr <= rd_ptr_next;
            count  <= count_next;
        end
    end

    inst_buffer_mem #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_mem (
        .clk     (clk),
        .wr_en   (push & ~flush_any & ~rst),
        .wr_addr (wr_ptr),
        .wr_data (pack_entry(fetch_pc_i, fetch_inst_i, fetch_excp_i, fetch_excp_num_i)),
        .rd_addr (rd_ptr),
        .rd_data (head)
    );

    // Decode sees an all-zero bubble whenever the buffer is empty.
    assign dec_pc_o       = dec_valid_o ? head.pc       : ZERO_WORD;
    assign dec_inst_o     = dec_valid_o ? head.inst     : ZERO_WORD;
    assign dec_excp_o     = dec_valid_o & head.excp;
    assign dec_excp_num_o = dec_valid_o ? head.excp_num : '0;
    assign count_o        = count;

endmodule
